// File: rtl/bin_maxpool2x2_pkg.sv
// Shared constants and FSM encoding for the binary 2x2 max-pool engine.
// Row words carry one binary image row, column c in bit c.
package bin_maxpool2x2_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  // Wide enough for N/2 of the largest legal image
  localparam int unsigned HALF_W = 4;

  localparam logic [15:0] TERM_WORD = 16'h00FF;

  localparam int unsigned N_SMALL = 8;
  localparam int unsigned N_MID   = 10;
  localparam int unsigned N_LARGE = 14;

  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StHdr   = 6'b000010,
    StRowA  = 6'b000100,
    StRowB  = 6'b001000,
    StWrite = 6'b010000,
    StTerm  = 6'b100000
  } state_e;

endpackage

// File: rtl/bin_maxpool2x2_if.sv
// Control and SRAM bus of the max-pool engine; master is the engine side,
// slave is the environment (controller plus both SRAMs).
interface bin_maxpool2x2_if
  import bin_maxpool2x2_pkg::*;
#(
    parameter int unsigned ADDR_W = bin_maxpool2x2_pkg::ADDR_W,
    parameter int unsigned DATA_W = bin_maxpool2x2_pkg::DATA_W
);

  logic              pool_run;
  logic              pool_busy;
  logic [ADDR_W-1:0] pool_sram_read_address;
  logic [DATA_W-1:0] sram_pool_read_data;
  logic [ADDR_W-1:0] pool_sram_write_address;
  logic [DATA_W-1:0] pool_sram_write_data;
  logic              pool_sram_write_enable;

  modport master (
    input  pool_run,
    input  sram_pool_read_data,
    output pool_busy,
    output pool_sram_read_address,
    output pool_sram_write_address,
    output pool_sram_write_data,
    output pool_sram_write_enable
  );

  modport slave (
    output pool_run,
    output sram_pool_read_data,
    input  pool_busy,
    input  pool_sram_read_address,
    input  pool_sram_write_address,
    input  pool_sram_write_data,
    input  pool_sram_write_enable
  );

endinterface

// File: rtl/bin_pool_row.sv
// Combinational 2x2 OR-pool of two source rows into one pooled row;
// only the low 'half' output bits are populated, the rest are zero.
module bin_pool_row
  import bin_maxpool2x2_pkg::*;
#(
    parameter int unsigned DATA_W = bin_maxpool2x2_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] row_a,
    input  logic [DATA_W-1:0] row_b,
    input  logic [HALF_W-1:0] half,
    output logic [DATA_W-1:0] pooled
);

  always_comb begin
    pooled = '0;
    for (int j = 0; j < int'(DATA_W / 2); j++) begin
      // Columns at or beyond N never reach a populated output bit
      if (j < int'({1'b0, half})) begin
        pooled[j] = row_a[2*j] | row_a[2*j+1] | row_b[2*j] | row_b[2*j+1];
      end
    end
  end

endmodule

// File: rtl/bin_maxpool2x2.sv
// Streams a list of binary images from the source SRAM, writing each image's
// 2x2 OR-pooled version (header N/2, then N/2 rows) and a final terminator.
module bin_maxpool2x2
  import bin_maxpool2x2_pkg::*;
#(
    parameter int unsigned ADDR_W = bin_maxpool2x2_pkg::ADDR_W,
    parameter int unsigned DATA_W = bin_maxpool2x2_pkg::DATA_W
) (
    input logic                    clk,
    input logic                    reset_b,
    bin_maxpool2x2_if.master       bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [HALF_W-1:0] HALF_ONE = HALF_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] rows_left_q, rows_left_d;
  logic [DATA_W-1:0] row_a_q;
  logic [DATA_W-1:0] pooled;
  logic [DATA_W-1:0] rdata;
  logic              hdr_legal;

  assign rdata = bus.sram_pool_read_data;

  always_comb begin
    hdr_legal = (rdata == DATA_W'(N_SMALL)) || (rdata == DATA_W'(N_MID)) ||
                (rdata == DATA_W'(N_LARGE));
  end

  bin_pool_row #(
    .DATA_W (DATA_W)
  ) u_pool_row (
    .row_a  (row_a_q),
    .row_b  (rdata),
    .half   (half_q),
    .pooled (pooled)
  );

  // The read address runs one word ahead of the word being consumed, so
  // it advances on the cycle before each consuming state is entered.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_ptr_d    = wr_ptr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    busy_d      = busy_q;
    half_d      = half_q;
    rows_left_d = rows_left_q;
    unique case (state_q)
      StIdle: begin
        rd_addr_d = '0;
        busy_d    = 1'b0;
        if (bus.pool_run) begin
          state_d   = StHdr;
          rd_addr_d = ADDR_ONE;
          wr_ptr_d  = '0;
          busy_d    = 1'b1;
        end
      end
      StHdr: begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + ADDR_ONE;
        if (hdr_legal) begin
          half_d      = rdata[HALF_W:1];
          rows_left_d = rdata[HALF_W:1];
          wr_data_d   = DATA_W'(rdata[HALF_W:1]);
          rd_addr_d   = rd_addr_q + ADDR_ONE;
          state_d     = StRowA;
        end else begin
          wr_data_d = DATA_W'(TERM_WORD);
          state_d   = StTerm;
        end
      end
      StRowA: begin
        state_d = StRowB;
      end
      StRowB: begin
        wr_en_d     = 1'b1;
        wr_addr_d   = wr_ptr_q;
        wr_ptr_d    = wr_ptr_q + ADDR_ONE;
        wr_data_d   = pooled;
        rows_left_d = rows_left_q - HALF_ONE;
        rd_addr_d   = rd_addr_q + ADDR_ONE;
        state_d     = StWrite;
      end
      StWrite: begin
        rd_addr_d = rd_addr_q + ADDR_ONE;
        state_d   = (rows_left_q == '0) ? StHdr : StRowA;
      end
      StTerm: begin
        rd_addr_d = '0;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_ptr_q    <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      half_q      <= '0;
      rows_left_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      half_q      <= half_d;
      rows_left_q <= rows_left_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StRowA) begin
      row_a_q <= rdata;
    end
  end

  assign bus.pool_busy               = busy_q;
  assign bus.pool_sram_read_address  = rd_addr_q;
  assign bus.pool_sram_write_address = wr_addr_q;
  assign bus.pool_sram_write_data    = wr_data_q;
  assign bus.pool_sram_write_enable  = wr_en_q;

endmodule

// File: tb/tb_bin_maxpool2x2.sv
// Directed bench for bin_maxpool2x2: small source SRAM model, write logger,
// hand-computed expected write sequences checked with immediate assertions.
module tb_bin_maxpool2x2;

  logic clk = 1'b0;
  logic reset_b;

  always #5 clk = ~clk;

  bin_maxpool2x2_if bus ();

  bin_maxpool2x2 dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  logic [15:0] src_mem [0:63];
  logic [11:0] log_a   [0:255];
  logic [15:0] log_d   [0:255];
  int          wr_cnt = 0;

  int n_err    = 0;
  int n_checks = 0;
  int exp_a[$];
  int exp_d[$];

  // Source SRAM: one-cycle registered read; destination writes logged
  always @(posedge clk) begin
    bus.sram_pool_read_data <= src_mem[bus.pool_sram_read_address[5:0]];
    if (bus.pool_sram_write_enable === 1'b1) begin
      if (wr_cnt < 256) begin
        log_a[wr_cnt] <= bus.pool_sram_write_address;
        log_d[wr_cnt] <= bus.pool_sram_write_data;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_w(input int a, input int d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic check_writes(input string tag, input int base);
    chk($sformatf("%s_count", tag), wr_cnt - base, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (base + i < wr_cnt && base + i < 256) begin
        chk($sformatf("%s_addr%0d", tag, i), {20'd0, log_a[base+i]}, exp_a[i]);
        chk($sformatf("%s_data%0d", tag, i), {16'd0, log_d[base+i]}, exp_d[i]);
      end
    end
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, bus.pool_busy, 1'b0);
    chk({tag, "_raddr"}, bus.pool_sram_read_address, 12'h000);
    chk({tag, "_waddr"}, bus.pool_sram_write_address, 12'h000);
    chk({tag, "_wdata"}, bus.pool_sram_write_data, 16'h0000);
    chk({tag, "_wen"}, bus.pool_sram_write_enable, 1'b0);
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 64; i++) src_mem[i] = 16'h0000;
  endtask

  // Pulse pool_run, then count busy cycles; poke_at re-asserts pool_run mid-run
  task automatic run_pool(input string tag, input int poke_at, output int busy_cycles);
    int cyc;
    @(negedge clk);
    bus.pool_run = 1'b1;
    @(negedge clk);
    bus.pool_run = 1'b0;
    chk({tag, "_busy_rise"}, bus.pool_busy, 1'b1);
    busy_cycles = 0;
    cyc = 0;
    while (bus.pool_busy === 1'b1 && cyc < 200) begin
      busy_cycles++;
      cyc++;
      bus.pool_run = (cyc == poke_at);
      @(negedge clk);
    end
    bus.pool_run = 1'b0;
    chk({tag, "_busy_fall"}, bus.pool_busy, 1'b0);
  endtask

  task automatic load_full14;
    clear_mem();
    src_mem[0] = 16'd14;
    for (int i = 1; i <= 14; i++) src_mem[i] = 16'hFFFF;
    src_mem[15] = 16'h00FF;
  endtask

  task automatic expect_full14;
    exp_w(0, 'h07);
    for (int i = 1; i <= 7; i++) exp_w(i, 'h7F);
    exp_w(8, 'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bc;

    reset_b      = 1'b0;
    bus.pool_run = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset_b = 1'b1;
    @(negedge clk);

    // 14x14 all ones
    load_full14();
    base = wr_cnt;
    run_pool("full14", 0, bc);
    chk("full14_busy_cycles", bc, 24);
    expect_full14();
    check_writes("full14", base);

    // 8x8 checkerboard
    clear_mem();
    src_mem[0] = 16'd8;
    for (int i = 1; i <= 8; i++) src_mem[i] = (i % 2 == 1) ? 16'h0055 : 16'h00AA;
    src_mem[9] = 16'h00FF;
    base = wr_cnt;
    run_pool("chk8", 0, bc);
    exp_w(0, 'h04);
    for (int i = 1; i <= 4; i++) exp_w(i, 'h0F);
    exp_w(5, 'hFF);
    check_writes("chk8", base);

    // 10x10 single pixel at row 3 col 5, garbage above column 9
    clear_mem();
    src_mem[0] = 16'd10;
    for (int i = 1; i <= 10; i++) src_mem[i] = 16'hFC00;
    src_mem[4]  = 16'hFC20;
    src_mem[11] = 16'h00FF;
    base = wr_cnt;
    run_pool("dot10", 0, bc);
    exp_w(0, 'h05);
    exp_w(1, 'h00);
    exp_w(2, 'h04);
    exp_w(3, 'h00);
    exp_w(4, 'h00);
    exp_w(5, 'h00);
    exp_w(6, 'hFF);
    check_writes("dot10", base);

    // 10x10 then 8x8 back-to-back; pool_run pulsed while busy must be ignored
    clear_mem();
    src_mem[0] = 16'd10;
    for (int i = 1; i <= 10; i++) src_mem[i] = 16'h03FF;
    src_mem[11] = 16'd8;
    for (int i = 12; i <= 19; i++) src_mem[i] = 16'h00FF;
    src_mem[20] = 16'h00FF;
    base = wr_cnt;
    run_pool("two", 5, bc);
    exp_w(0, 'h05);
    for (int i = 1; i <= 5; i++) exp_w(i, 'h1F);
    exp_w(6, 'h04);
    for (int i = 7; i <= 10; i++) exp_w(i, 'h0F);
    exp_w(11, 'hFF);
    check_writes("two", base);

    // Terminator only
    clear_mem();
    src_mem[0] = 16'h00FF;
    base = wr_cnt;
    run_pool("term", 0, bc);
    chk("term_busy_le4", (bc <= 4), 1'b1);
    exp_w(0, 'hFF);
    check_writes("term", base);

    // Illegal header behaves as terminator
    clear_mem();
    src_mem[0] = 16'd12;
    base = wr_cnt;
    run_pool("bad_n", 0, bc);
    exp_w(0, 'hFF);
    check_writes("bad_n", base);

    // Reset mid-image
    load_full14();
    @(negedge clk);
    bus.pool_run = 1'b1;
    @(negedge clk);
    bus.pool_run = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    check_outputs_zero("midrst");
    base = wr_cnt;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_writes", wr_cnt - base, 0);
    chk("midrst_idle_busy", bus.pool_busy, 1'b0);

    base = wr_cnt;
    run_pool("rerun", 0, bc);
    chk("rerun_busy_cycles", bc, 24);
    expect_full14();
    check_writes("rerun", base);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bin_maxpool2x2.md
BIN_MAXPOOL2X2 -- requirements
Module: bin_maxpool2x2

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the width of both SRAM address ports.
REQ-002 Parameter DATA_W, default 16, SHALL set the width of the SRAM data words; one word holds one binary image row, column c in bit c.
REQ-003 clk  input  1  SHALL be the clock; all logic samples on its rising edge.
REQ-004 reset_b  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 pool_run  input  1  SHALL be the start pulse, sampled only in IDLE.
REQ-006 pool_busy  output  1  SHALL be high from the cycle after an accepted pool_run until the terminator write completes.
REQ-007 pool_sram_read_address  output  ADDR_W  SHALL be the registered read address of the source SRAM, which holds the conv-stage output.
REQ-008 sram_pool_read_data  input  DATA_W  SHALL be the read data, valid one cycle after the address is registered.
REQ-009 pool_sram_write_address  output  ADDR_W  SHALL be the registered write address of the destination SRAM.
REQ-010 pool_sram_write_data  output  DATA_W  SHALL be the registered write data.
REQ-011 pool_sram_write_enable  output  1  SHALL be the registered write strobe; one word is written per high cycle.

Function
REQ-012 The source layout SHALL be: a header word N at read address 0, then N row words, then the next header, and so on; header 16'h00FF SHALL terminate the list.
REQ-013 Legal N SHALL be 8, 10 and 14; any other non-terminator header SHALL be handled exactly as the terminator.
REQ-014 FSM states SHALL be IDLE, HDR, ROW_A, ROW_B, WRITE and TERM.
- IDLE->HDR on pool_run.
- HDR->ROW_A on a legal N.
- HDR->TERM on the terminator.
- ROW_A->ROW_B.
- ROW_B->WRITE.
- WRITE->ROW_A while pooled rows remain; WRITE->HDR when all rows are done.
- TERM->IDLE.
REQ-015 For each legal image, the block SHALL first write header N/2, then N/2 pooled rows.
REQ-016 Pooled row k, bit j (j < N/2) SHALL be the OR of source bits (2k,2j), (2k,2j+1), (2k+1,2j) and (2k+1,2j+1); bits j >= N/2 SHALL be 0.
REQ-017 Source bits at columns >= N SHALL be ignored.
REQ-018 The read pointer SHALL advance by one word per row consumed, so consecutive images are read back-to-back.
REQ-019 The write pointer SHALL start at 0 on each accepted pool_run and advance by one per written word.
REQ-020 On TERM the block SHALL write 16'h00FF at the current write pointer, then drop pool_busy the following cycle.
REQ-021 pool_run asserted while busy SHALL be ignored.
REQ-022 The read pointer SHALL restart at 0 on each accepted pool_run.
REQ-023 Both pointers SHALL wrap modulo 2^ADDR_W without error.
REQ-024 Write enable SHALL never be high on two words with the same address within one run.

Reset
REQ-025 On reset_b low, the FSM SHALL enter IDLE and all outputs SHALL go to 0 (busy, both addresses, write data, write enable) immediately and asynchronously.
REQ-026 Reset mid-operation SHALL abandon the run with no further writes; a fresh pool_run SHALL then restart from read address 0.
REQ-027 Internal datapath row registers need no reset.

Structure
REQ-028 A shared package SHALL hold ADDR_W, DATA_W, TERM_WORD=16'h00FF, the legal-N constants and the FSM state encoding (one-hot).
REQ-029 One sub-module, bin_pool_row, SHALL implement the combinational two-row/column-pair OR of REQ-016 given N.

Verification
REQ-030 Bench SHALL cover: one 14x14 image of all 0xFFFF rows followed by the terminator -> writes 0x0007 at address 0, 0x007F at addresses 1..7, 0x00FF at address 8, then busy falls.
REQ-031 Bench SHALL cover: an 8x8 checkerboard (rows alternating 0x0055/0x00AA) -> header 0x0004, then four rows of 0x000F, then the terminator.
REQ-032 Bench SHALL cover: a 10x10 image with a single 1 at row 3, column 5, plus garbage in bits 15:10 -> header 0x0005, row 1 = 0x0004, all other rows 0x0000.
REQ-033 Bench SHALL cover: a 10x10 image followed by an 8x8 image, then the terminator -> write addresses 0..5 (first image), 6..10 (second), terminator at 11.
REQ-034 Bench SHALL cover: a source holding only header 0x00FF -> a single write of 0x00FF at address 0, busy high for at most 4 cycles.
REQ-035 Bench SHALL cover: reset_b pulsed low mid-image -> all outputs 0 within the same cycle and no writes afterwards; a re-run then reproduces the REQ-030 results exactly.
